// File: rtl/decoder_nto2n_reg_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
//
// Shared types for the registered N-to-2**N decoder:
//   mode_e       - request decode mode carried on the 2-bit mode field
//   fsm_state_e  - wrapper FSM states (idle / scanning / scan-complete pulse)
//   is_therm()   - mode classification helper used by the request path
// ---------------------------------------------------------------------------
package decoder_pkg;

    // Request decode mode. The reserved encoding decodes like one-hot.
    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // Wrapper FSM. S_DONE lasts exactly one cycle and carries scan_done.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } fsm_state_e;

    // True only for the thermometer mode; reserved falls back to one-hot.
    function automatic logic is_therm(input mode_e m);
        return (m == MODE_THERM);
    endfunction

endpackage

// File: rtl/decoder_nto2n_reg_if.sv
// ---------------------------------------------------------------------------
// decoder_nto2n_reg_if
//
// Request/result bundle for decoder_nto2n_reg.
//   Request side : in_valid, in_ready, sel[SEL_W], en, mode[2]
//   Result side  : out_valid, out_ready, y[OUT_N], err
//   Status       : busy, scan_done
// Modports:
//   master - the requester/consumer (drives requests, accepts results)
//   slave  - the decoder itself
// ---------------------------------------------------------------------------
interface decoder_nto2n_reg_if #(
    parameter int SEL_W = 4,
    parameter int OUT_N = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_N-1:0] y;
    logic             err;
    logic             busy;
    logic             scan_done;

    modport master (
        output in_valid,
        output sel,
        output en,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  err,
        input  busy,
        input  scan_done
    );

    modport slave (
        input  in_valid,
        input  sel,
        input  en,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output err,
        output busy,
        output scan_done
    );

endinterface

// File: rtl/decoder_nto2n_reg_decode_core.sv
// ---------------------------------------------------------------------------
// decode_core
//
// Purely combinational select decoder.
//   sel   [SEL_W]  binary select
//   en             0 forces y=0 and err=0
//   therm          0: one-hot (y[sel]=1), 1: thermometer (y[i]=1 for i<=sel)
//   y     [OUT_N]  decoded word, all-zero when sel is out of range
//   err            sel >= OUT_N while enabled
//
// The range test is done on SEL_W+1 bits so that OUT_N == 2**SEL_W is
// representable and never reports an error.
// ---------------------------------------------------------------------------
module decode_core #(
    parameter int SEL_W = 4,
    parameter int OUT_N = 16
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic             therm,
    output logic [OUT_N-1:0] y,
    output logic             err
);

    localparam logic [SEL_W:0] LIMIT = (SEL_W+1)'(OUT_N);

    logic [SEL_W:0] sel_ext;
    logic           in_range;

    assign sel_ext  = {1'b0, sel};
    assign in_range = (sel_ext < LIMIT);
    assign err      = en && !in_range;

    // One comparator per output bit; the thermometer form only differs in
    // using <= instead of ==.
    generate
        for (genvar gi = 0; gi < OUT_N; gi++) begin : g_bit
            localparam logic [SEL_W:0] BIT_IDX = (SEL_W+1)'(gi);
            logic hit;
            assign hit   = therm ? (BIT_IDX <= sel_ext) : (BIT_IDX == sel_ext);
            assign y[gi] = en && in_range && hit;
        end
    endgenerate

endmodule

// File: rtl/decoder_nto2n_reg.sv
// ---------------------------------------------------------------------------
// decoder_nto2n_reg
//
// Registered N-to-OUT_N decoder with valid/ready handshake and a self-driven
// scan mode that walks a one-hot bit across every output.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset (aborts any scan, no scan_done)
//   bus   - decoder_nto2n_reg_if.slave:
//             in_valid/in_ready/sel/en/mode   request
//             out_valid/out_ready/y/err       single-entry result register
//             busy                            scan in progress (SCAN or DONE)
//             scan_done                       one-cycle pulse after last beat
//
// A single decode_core serves both paths: in IDLE it decodes the incoming
// request, in SCAN it decodes the index of the *next* beat so that the
// result register can be refilled on the same edge the current beat is taken.
// ---------------------------------------------------------------------------
module decoder_nto2n_reg
    import decoder_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int OUT_N = 16
) (
    input logic                clk,
    input logic                rst,
    decoder_nto2n_reg_if.slave bus
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_N - 1);
    localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);

    fsm_state_e       state_reg;
    logic [SEL_W-1:0] idx_reg;
    logic [OUT_N-1:0] y_reg;
    logic             err_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic             scan_done_reg;

    mode_e            req_mode;
    logic             in_ready_int;
    logic             accept;
    logic             out_take;
    logic             scan_start;
    logic             last_beat;

    logic [SEL_W-1:0] core_sel;
    logic             core_en;
    logic             core_therm;
    logic [OUT_N-1:0] core_y;
    logic             core_err;

    assign req_mode = mode_e'(bus.mode);

    // The output register can take a new beat when it is empty or being
    // drained this cycle; requests are only taken while idle.
    assign in_ready_int = (state_reg == S_IDLE) && (!out_valid_reg || bus.out_ready);
    assign accept       = bus.in_valid && in_ready_int;
    assign out_take     = out_valid_reg && bus.out_ready;
    assign scan_start   = accept && (req_mode == MODE_SCAN) && bus.en;
    assign last_beat    = (idx_reg == LAST_IDX);

    // Decoder input steering.
    //  - SCAN: next index, always enabled, one-hot.
    //  - IDLE with a scan request: index 0 for the first beat; en passes
    //    through so a disabled scan request yields a single all-zero beat.
    //  - otherwise: the request as presented.
    always_comb begin
        core_sel   = bus.sel;
        core_en    = bus.en;
        core_therm = is_therm(req_mode);
        if (state_reg == S_SCAN) begin
            core_sel   = idx_reg + IDX_ONE;
            core_en    = 1'b1;
            core_therm = 1'b0;
        end else if (req_mode == MODE_SCAN) begin
            core_sel   = '0;
            core_therm = 1'b0;
        end
    end

    decode_core #(
        .SEL_W (SEL_W),
        .OUT_N (OUT_N)
    ) u_core (
        .sel   (core_sel),
        .en    (core_en),
        .therm (core_therm),
        .y     (core_y),
        .err   (core_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            y_reg         <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            scan_done_reg <= 1'b0;
        end else begin
            scan_done_reg <= 1'b0;
            unique case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        // A new beat overwrites the register even if the
                        // previous one is being drained on this same edge.
                        y_reg         <= core_y;
                        err_reg       <= core_err;
                        out_valid_reg <= 1'b1;
                        if (scan_start) begin
                            state_reg <= S_SCAN;
                            idx_reg   <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end else if (out_take) begin
                        out_valid_reg <= 1'b0;
                    end
                end

                S_SCAN: begin
                    // out_valid is held high for the whole scan, so a take
                    // here is simply out_ready.
                    if (out_take) begin
                        if (last_beat) begin
                            state_reg     <= S_DONE;
                            out_valid_reg <= 1'b0;
                            scan_done_reg <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + IDX_ONE;
                            y_reg   <= core_y;
                            err_reg <= core_err;
                        end
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                    idx_reg   <= '0;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.y         = y_reg;
    assign bus.err       = err_reg;
    assign bus.busy      = busy_reg;
    assign bus.scan_done = scan_done_reg;

endmodule

// File: tb/tb_decoder_nto2n_reg.sv
// ---------------------------------------------------------------------------
// tb_decoder_nto2n_reg
//
// Two decoder instances (SEL_W=4 with OUT_N=16 and OUT_N=12) share clk/rst.
// A queue model holds the beats each instance still owes its consumer:
// a decode request adds one beat, an enabled scan adds OUT_N beats, and
// the front of the queue is what y/err must show while out_valid is high.
// Directed pins with literal values anchor the model at key points.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decoder_nto2n_reg;

    typedef struct packed {
        logic [15:0] y;
        logic        err;
        logic        scan;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       s_in_valid;
    logic [1:0]       s_en;
    logic [1:0]       s_out_ready;
    logic [1:0][3:0]  s_sel;
    logic [1:0][1:0]  s_mode;

    logic [1:0][15:0] d_y;
    logic [1:0]       d_in_ready;
    logic [1:0]       d_out_valid;
    logic [1:0]       d_err;
    logic [1:0]       d_busy;
    logic [1:0]       d_done;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int NOUT = (gi == 0) ? 16 : 12;
            decoder_nto2n_reg_if #(.SEL_W(4), .OUT_N(NOUT)) ifc ();
            assign ifc.in_valid   = s_in_valid[gi];
            assign ifc.sel        = s_sel[gi];
            assign ifc.en         = s_en[gi];
            assign ifc.mode       = s_mode[gi];
            assign ifc.out_ready  = s_out_ready[gi];
            assign d_y[gi]        = 16'(ifc.y);
            assign d_in_ready[gi] = ifc.in_ready;
            assign d_out_valid[gi]= ifc.out_valid;
            assign d_err[gi]      = ifc.err;
            assign d_busy[gi]     = ifc.busy;
            assign d_done[gi]     = ifc.scan_done;
            decoder_nto2n_reg #(.SEL_W(4), .OUT_N(NOUT)) dut (
                .clk (clk),
                .rst (rst),
                .bus (ifc.slave)
            );
        end
    endgenerate

    // ---------------- model ----------------
    beat_t mq [2][$];
    bit    m_done [2];
    int    total = 0;
    int    bad   = 0;

    function automatic int n_of(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic beat_t decode_req(input int n, input int sel, input bit en, input logic [1:0] md);
        beat_t b;
        b = '0;
        if (!en) return b;
        if (sel >= n) begin
            b.err = 1'b1;
            return b;
        end
        if (md == 2'b01) b.y = 16'((32'd1 << (sel + 1)) - 32'd1);
        else             b.y = 16'(32'd1 << sel);
        return b;
    endfunction

    function automatic bit m_busy(input int k);
        if (m_done[k]) return 1'b1;
        for (int i = 0; i < mq[k].size(); i++)
            if (mq[k][i].scan) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit    rdy_m;
        beat_t b;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                m_done[k] = 1'b0;
            end else begin
                rdy_m = !m_busy(k) && (mq[k].size() == 0 || s_out_ready[k]);
                m_done[k] = 1'b0;
                if (mq[k].size() > 0 && s_out_ready[k]) begin
                    b = mq[k].pop_front();
                    m_done[k] = b.last;
                end
                if (s_in_valid[k] && rdy_m) begin
                    if (s_mode[k] == 2'b10 && s_en[k]) begin
                        for (int i = 0; i < n_of(k); i++) begin
                            b      = '0;
                            b.y    = 16'(32'd1 << i);
                            b.scan = 1'b1;
                            b.last = (i == n_of(k) - 1);
                            mq[k].push_back(b);
                        end
                    end else begin
                        mq[k].push_back(decode_req(n_of(k), int'(s_sel[k]), s_en[k], s_mode[k]));
                    end
                end
            end
        end
    end

    // ---------------- compare ----------------
    function automatic void cmp(input int k, input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL dut%0d %s: got %h want %h at %0t", k, nm, act, exp, $time);
        end
    endfunction

    bit          lit_on = 1'b0;
    int          lit_k;
    bit          lit_chk_y;
    logic [15:0] lit_y;
    bit          lit_err, lit_ov, lit_rdy, lit_busy, lit_done;

    always @(negedge clk) begin
        bit    ov_e;
        beat_t f;
        for (int k = 0; k < 2; k++) begin
            ov_e = (mq[k].size() > 0);
            cmp(k, "out_valid", 16'(d_out_valid[k]), 16'(ov_e));
            cmp(k, "in_ready", 16'(d_in_ready[k]), 16'(!m_busy(k) && (!ov_e || s_out_ready[k])));
            cmp(k, "busy", 16'(d_busy[k]), 16'(m_busy(k)));
            cmp(k, "scan_done", 16'(d_done[k]), 16'(m_done[k]));
            if (ov_e) begin
                f = mq[k][0];
                cmp(k, "y", d_y[k], f.y);
                cmp(k, "err", 16'(d_err[k]), 16'(f.err));
            end
        end
        if (lit_on) begin
            if (lit_chk_y) cmp(lit_k, "pin_y", d_y[lit_k], lit_y);
            cmp(lit_k, "pin_err", 16'(d_err[lit_k]), 16'(lit_err));
            cmp(lit_k, "pin_out_valid", 16'(d_out_valid[lit_k]), 16'(lit_ov));
            cmp(lit_k, "pin_in_ready", 16'(d_in_ready[lit_k]), 16'(lit_rdy));
            cmp(lit_k, "pin_busy", 16'(d_busy[lit_k]), 16'(lit_busy));
            cmp(lit_k, "pin_scan_done", 16'(d_done[lit_k]), 16'(lit_done));
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] tbl [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int k, input int sel, input bit en, input logic [1:0] md);
        s_in_valid[k] = 1'b1;
        s_sel[k]      = 4'(sel);
        s_en[k]       = en;
        s_mode[k]     = md;
    endtask

    task automatic idle(input int k);
        s_in_valid[k] = 1'b0;
    endtask

    task automatic pin(input int k, input bit chk_y, input logic [15:0] y, input bit e,
                       input bit ov, input bit rdy, input bit bsy, input bit dn);
        lit_k     = k;
        lit_chk_y = chk_y;
        lit_y     = y;
        lit_err   = e;
        lit_ov    = ov;
        lit_rdy   = rdy;
        lit_busy  = bsy;
        lit_done  = dn;
        lit_on    = 1'b1;
        @(negedge clk);
        #1;
        lit_on = 1'b0;
    endtask

    initial begin
        tbl = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
                16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h8000};
        s_in_valid  = '0;
        s_en        = '0;
        s_sel       = '0;
        s_mode      = '0;
        s_out_ready = 2'b11;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pin(0, 1, 16'h0000, 0, 0, 1, 0, 0);

        // one-hot sweep, back to back
        for (int i = 0; i < 16; i++) begin
            req(0, i, 1, 2'b00);
            tick();
            pin(0, 1, tbl[i], 0, 1, 1, 0, 0);
            $display("onehot sel=%0d y=%h", i, d_y[0]);
        end
        idle(0);
        tick();

        // range / enable on the 12-output instance
        req(1, 13, 1, 2'b00); tick(); pin(1, 1, 16'h0000, 1, 1, 1, 0, 0);
        $display("range sel=13 y=%h err=%0b", d_y[1], d_err[1]);
        req(1, 5, 0, 2'b00);  tick(); pin(1, 1, 16'h0000, 0, 1, 1, 0, 0);
        $display("enable0 sel=5 y=%h err=%0b", d_y[1], d_err[1]);
        req(1, 11, 1, 2'b00); tick(); pin(1, 1, 16'h0800, 0, 1, 1, 0, 0);
        $display("edge sel=11 y=%h", d_y[1]);
        req(1, 12, 1, 2'b00); tick(); pin(1, 1, 16'h0000, 1, 1, 1, 0, 0);
        $display("edge sel=12 y=%h err=%0b", d_y[1], d_err[1]);
        req(1, 11, 1, 2'b01); tick(); pin(1, 1, 16'h0FFF, 0, 1, 1, 0, 0);
        $display("therm12 sel=11 y=%h", d_y[1]);
        idle(1);
        tick();

        // thermometer, reserved mode, disabled scan
        req(0, 3, 1, 2'b01);  tick(); pin(0, 1, 16'h000F, 0, 1, 1, 0, 0);
        $display("therm sel=3 y=%h", d_y[0]);
        req(0, 15, 1, 2'b01); tick(); pin(0, 1, 16'hFFFF, 0, 1, 1, 0, 0);
        $display("therm sel=15 y=%h", d_y[0]);
        req(0, 0, 1, 2'b01);  tick(); pin(0, 1, 16'h0001, 0, 1, 1, 0, 0);
        $display("therm sel=0 y=%h", d_y[0]);
        req(0, 9, 1, 2'b11);  tick(); pin(0, 1, 16'h0200, 0, 1, 1, 0, 0);
        $display("rsvd sel=9 y=%h", d_y[0]);
        req(0, 5, 0, 2'b10);  tick(); pin(0, 1, 16'h0000, 0, 1, 1, 0, 0);
        $display("scan en=0 y=%h busy=%0b", d_y[0], d_busy[0]);
        idle(0);
        tick();

        // backpressure
        req(0, 7, 1, 2'b00);
        tick();
        s_out_ready[0] = 1'b0;
        req(0, 2, 1, 2'b00);
        for (int c = 0; c < 3; c++) begin
            pin(0, 1, 16'h0080, 0, 1, 0, 0, 0);
            $display("stall cycle=%0d y=%h in_ready=%0b", c, d_y[0], d_in_ready[0]);
            tick();
        end
        s_out_ready[0] = 1'b1;
        pin(0, 1, 16'h0080, 0, 1, 1, 0, 0);
        tick();
        idle(0);
        pin(0, 1, 16'h0004, 0, 1, 1, 0, 0);
        $display("release y=%h", d_y[0]);
        tick();

        // scan with toggling out_ready; a stray request must be ignored
        req(0, 5, 1, 2'b10);
        tick();
        req(0, 3, 1, 2'b00);
        for (int b = 0; b < 16; b++) begin
            s_out_ready[0] = 1'b0;
            pin(0, 1, tbl[b], 0, 1, 0, 1, 0);
            tick();
            s_out_ready[0] = 1'b1;
            if (b == 15) idle(0);
            pin(0, 1, tbl[b], 0, 1, 0, 1, 0);
            $display("scan beat=%0d y=%h busy=%0b", b, d_y[0], d_busy[0]);
            tick();
        end
        pin(0, 0, 16'h0000, 0, 0, 0, 1, 1);
        $display("scan done pulse=%0b", d_done[0]);
        tick();
        pin(0, 0, 16'h0000, 0, 0, 1, 0, 0);
        $display("scan idle in_ready=%0b", d_in_ready[0]);

        // reset in the middle of a scan
        req(0, 0, 1, 2'b10);
        tick();
        idle(0);
        for (int b = 0; b < 6; b++) begin
            pin(0, 1, tbl[b], 0, 1, 0, 1, 0);
            tick();
        end
        pin(0, 1, tbl[6], 0, 1, 0, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pin(0, 1, 16'h0000, 0, 0, 1, 0, 0);
        $display("midscan reset y=%h busy=%0b", d_y[0], d_busy[0]);
        tick();
        pin(0, 1, 16'h0000, 0, 0, 1, 0, 0);
        req(0, 10, 1, 2'b00);
        tick();
        idle(0);
        pin(0, 1, 16'h0400, 0, 1, 1, 0, 0);
        $display("post-reset sel=10 y=%h", d_y[0]);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
